// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one Booth multiplier between two requesters.
// Accepts an operand pair, pulses mul_start, waits for done under a watchdog, returns the product.
module mul_arbiter #(
   parameter int WIDTH   = 32,
   parameter int PROD_W  = 2*WIDTH+3,
   parameter int TIMEOUT = 63
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_valid,
   output logic              r0_ready,
   input  logic [WIDTH-1:0]  r0_x,
   input  logic [WIDTH-1:0]  r0_y,
   input  logic              r1_valid,
   output logic              r1_ready,
   input  logic [WIDTH-1:0]  r1_x,
   input  logic [WIDTH-1:0]  r1_y,
   output logic              rsp0_valid,
   output logic              rsp1_valid,
   input  logic              rsp0_ready,
   input  logic              rsp1_ready,
   output logic [PROD_W-1:0] rsp_product,
   output logic              rsp_err,
   output logic              mul_start,
   output logic [WIDTH-1:0]  mul_x,
   output logic [WIDTH-1:0]  mul_y,
   input  logic              mul_done,
   input  logic [PROD_W-1:0] mul_product,
   output logic              busy
);

   localparam int WD_W = $clog2(TIMEOUT+1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT-1);

   typedef enum logic [3:0] {
      IDLE   = 4'b0001,
      LAUNCH = 4'b0010,
      WAIT   = 4'b0100,
      RESP   = 4'b1000
   } state_t;

   state_t            state_reg, state_next;
   logic              last_grant_reg, last_grant_next;
   logic              grant_id_reg, grant_id_next;
   logic [WIDTH-1:0]  mul_x_reg, mul_x_next;
   logic [WIDTH-1:0]  mul_y_reg, mul_y_next;
   logic [PROD_W-1:0] rsp_product_reg, rsp_product_next;
   logic              rsp_err_reg, rsp_err_next;
   logic [WD_W-1:0]   wd_cnt_reg, wd_cnt_next;

   logic              sel;
   logic [1:0]        req_valid, req_ready, rsp_valid_vec, rsp_ready_vec;
   logic              accept, rsp_hs;

   assign req_valid     = {r1_valid, r0_valid};
   assign rsp_ready_vec = {rsp1_ready, rsp0_ready};

   // Both valid: the requester that did not win last time gets the grant.
   always_comb begin
      sel = r1_valid;
      if (r0_valid && r1_valid)
         sel = ~last_grant_reg;
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         assign req_ready[gi]     = (state_reg == IDLE) & req_valid[gi] & (sel == 1'(gi));
         assign rsp_valid_vec[gi] = (state_reg == RESP) & (grant_id_reg == 1'(gi));
      end
   endgenerate

   assign r0_ready    = req_ready[0];
   assign r1_ready    = req_ready[1];
   assign rsp0_valid  = rsp_valid_vec[0];
   assign rsp1_valid  = rsp_valid_vec[1];
   assign accept      = |req_ready;
   assign rsp_hs      = |(rsp_valid_vec & rsp_ready_vec);
   assign mul_start   = (state_reg == LAUNCH);
   assign busy        = (state_reg != IDLE);
   assign mul_x       = mul_x_reg;
   assign mul_y       = mul_y_reg;
   assign rsp_product = rsp_product_reg;
   assign rsp_err     = rsp_err_reg;

   always_comb begin
      state_next       = state_reg;
      last_grant_next  = last_grant_reg;
      grant_id_next    = grant_id_reg;
      mul_x_next       = mul_x_reg;
      mul_y_next       = mul_y_reg;
      rsp_product_next = rsp_product_reg;
      rsp_err_next     = rsp_err_reg;
      wd_cnt_next      = wd_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               mul_x_next    = sel ? r1_x : r0_x;
               mul_y_next    = sel ? r1_y : r0_y;
               grant_id_next = sel;
               state_next    = LAUNCH;
            end
         end
         LAUNCH: begin
            wd_cnt_next = '0;
            state_next  = WAIT;
         end
         WAIT: begin
            wd_cnt_next = wd_cnt_reg + 1'b1;
            // A done arriving on the last watchdog cycle still counts as success.
            if (mul_done) begin
               rsp_product_next = mul_product;
               rsp_err_next     = 1'b0;
               state_next       = RESP;
            end else if (wd_cnt_reg == WD_LAST) begin
               rsp_product_next = '0;
               rsp_err_next     = 1'b1;
               state_next       = RESP;
            end
         end
         RESP: begin
            if (rsp_hs) begin
               last_grant_next = grant_id_reg;
               state_next      = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         last_grant_reg  <= 1'b1;
         grant_id_reg    <= 1'b0;
         mul_x_reg       <= '0;
         mul_y_reg       <= '0;
         rsp_product_reg <= '0;
         rsp_err_reg     <= 1'b0;
         wd_cnt_reg      <= '0;
      end else begin
         state_reg       <= state_next;
         last_grant_reg  <= last_grant_next;
         grant_id_reg    <= grant_id_next;
         mul_x_reg       <= mul_x_next;
         mul_y_reg       <= mul_y_next;
         rsp_product_reg <= rsp_product_next;
         rsp_err_reg     <= rsp_err_next;
         wd_cnt_reg      <= wd_cnt_next;
      end
   end

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter: stimulus queues expectations, monitors compare on handshakes.
`timescale 1ns/1ps
module tb_mul_arbiter;
   localparam int WIDTH   = 32;
   localparam int PROD_W  = 67;
   localparam int TIMEOUT = 63;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              r0_valid = 1'b0, r1_valid = 1'b0;
   logic              r0_ready, r1_ready;
   logic [WIDTH-1:0]  r0_x = '0, r0_y = '0, r1_x = '0, r1_y = '0;
   logic              rsp0_valid, rsp1_valid;
   logic              rsp0_ready = 1'b1, rsp1_ready = 1'b1;
   logic [PROD_W-1:0] rsp_product;
   logic              rsp_err, mul_start, busy;
   logic [WIDTH-1:0]  mul_x, mul_y;
   logic              mul_done;
   logic [PROD_W-1:0] mul_product;

   logic              model_done = 1'b0, force_done = 1'b0;
   logic [PROD_W-1:0] model_prod = '0, force_prod = '0;
   assign mul_done    = model_done | force_done;
   assign mul_product = force_done ? force_prod : model_prod;

   always #5 clk = ~clk;

   mul_arbiter #(.WIDTH(WIDTH), .PROD_W(PROD_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_x(r0_x), .r0_y(r0_y),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_x(r1_x), .r1_y(r1_y),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
      .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
      .rsp_product(rsp_product), .rsp_err(rsp_err),
      .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y),
      .mul_done(mul_done), .mul_product(mul_product), .busy(busy)
   );

   typedef struct { int id; logic [WIDTH-1:0] x; logic [WIDTH-1:0] y; } acc_t;
   typedef struct { int id; logic [PROD_W-1:0] prod; logic err; int lat; } rsp_t;

   acc_t acc_q[$];
   acc_t launch_q[$];
   rsp_t rsp_q[$];

   int total = 0, bad = 0;
   int cyc = 0, acc_count = 0, rsp_count = 0, acc_cyc = 0, rise_cyc = 0;
   bit done_en = 1'b1;
   int done_delay = 15;

   task automatic check(input string name, input logic [PROD_W-1:0] act, input logic [PROD_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic exp_acc(input int id, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      acc_t e;
      e.id = id; e.x = x; e.y = y;
      acc_q.push_back(e);
   endtask

   task automatic exp_rsp(input int id, input logic [PROD_W-1:0] prod, input logic err, input int lat);
      rsp_t e;
      e.id = id; e.prod = prod; e.err = err; e.lat = lat;
      rsp_q.push_back(e);
   endtask

   task automatic wait_acc_to(input int target);
      int k = 0;
      while (acc_count < target && k < 300) begin
         @(posedge clk); #1; k++;
      end
      if (acc_count < target) begin
         total++; bad++;
         $display("FAIL accept_timeout: accepts=%0d required=%0d", acc_count, target);
      end
   endtask

   task automatic wait_rsp_to(input int target);
      int k = 0;
      while (rsp_count < target && k < 300) begin
         @(posedge clk); #1; k++;
      end
      if (rsp_count < target) begin
         total++; bad++;
         $display("FAIL response_timeout: responses=%0d required=%0d", rsp_count, target);
      end
      @(posedge clk); #1;
   endtask

   always @(posedge clk) cyc++;

   // Accept monitor: grant order and the operands the multiplier must later see.
   acc_t am_e;
   int   am_id;
   always @(negedge clk) begin
      if (!rst && (r0_ready || r1_ready)) begin
         check("single_ready", PROD_W'(r0_ready & r1_ready), '0);
         am_id = r1_ready ? 1 : 0;
         acc_count++;
         acc_cyc = cyc;
         if (acc_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_accept: got r%0d required none", am_id);
         end else begin
            am_e = acc_q.pop_front();
            check("grant_id", PROD_W'(am_id), PROD_W'(am_e.id));
            launch_q.push_back(am_e);
         end
      end
   end

   // Response monitor: compares on every response handshake.
   rsp_t rm_e;
   int   rm_id;
   logic rm_prev = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         rm_prev = 1'b0;
      end else begin
         if ((rsp0_valid || rsp1_valid) && !rm_prev) rise_cyc = cyc;
         rm_prev = rsp0_valid || rsp1_valid;
         if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
            rm_id = rsp1_valid ? 1 : 0;
            rsp_count++;
            $display("rsp id=%0d product=%h err=%0b", rm_id, rsp_product, rsp_err);
            check("rsp_one_valid", PROD_W'(rsp0_valid & rsp1_valid), '0);
            if (rsp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_rsp: got r%0d required none", rm_id);
            end else begin
               rm_e = rsp_q.pop_front();
               check("rsp_id", PROD_W'(rm_id), PROD_W'(rm_e.id));
               check("rsp_product", rsp_product, rm_e.prod);
               check("rsp_err", PROD_W'(rsp_err), PROD_W'(rm_e.err));
               if (rm_e.lat >= 0)
                  check("latency", PROD_W'(rise_cyc - acc_cyc), PROD_W'(rm_e.lat));
            end
         end
      end
   end

   // Multiplier stand-in: done fires done_delay cycles after the start pulse.
   int   m_cnt = 0;
   bit   m_pend = 1'b0;
   acc_t m_e;
   logic [WIDTH-1:0] m_x = '0, m_y = '0;
   logic signed [63:0] m_p64;
   always @(negedge clk or posedge rst) begin
      if (rst) begin
         m_pend = 1'b0;
         model_done = 1'b0;
      end else begin
         model_done = 1'b0;
         if (m_pend) begin
            if (m_cnt <= 1) begin
               m_p64 = $signed(m_x) * $signed(m_y);
               model_prod = {{(PROD_W-64){m_p64[63]}}, m_p64};
               model_done = 1'b1;
               m_pend = 1'b0;
            end else begin
               m_cnt--;
            end
         end
         if (mul_start) begin
            if (launch_q.size() == 0) begin
               total++; bad++;
               $display("FAIL unexpected_start: got mul_start=1 required 0");
            end else begin
               m_e = launch_q.pop_front();
               check("launch_x", PROD_W'(mul_x), PROD_W'(m_e.x));
               check("launch_y", PROD_W'(mul_y), PROD_W'(m_e.y));
            end
            m_x = mul_x;
            m_y = mul_y;
            if (done_en) begin
               m_pend = 1'b1;
               m_cnt  = done_delay;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   int a0, r0c, k;
   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_mul_x", PROD_W'(mul_x), '0);
      check("reset_mul_y", PROD_W'(mul_y), '0);
      check("reset_product", rsp_product, '0);
      check("reset_err", PROD_W'(rsp_err), '0);
      check("reset_busy", PROD_W'(busy), '0);
      check("reset_start", PROD_W'(mul_start), '0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single request, latency 17 with done 15 cycles after start.
      done_delay = 15;
      exp_acc(0, 32'd2, 32'd3);
      exp_rsp(0, 67'd6, 1'b0, 17);
      r0_x = 32'd2; r0_y = 32'd3; r0_valid = 1'b1;
      wait_acc_to(acc_count + 1);
      r0_valid = 1'b0;
      wait_rsp_to(1);

      // Signed operands from requester 1.
      done_delay = 4;
      exp_acc(1, 32'hFFFF_FFFB, 32'd7);
      exp_rsp(1, 67'h7_FFFF_FFFF_FFFF_FFDD, 1'b0, 6);
      r1_x = 32'hFFFF_FFFB; r1_y = 32'd7; r1_valid = 1'b1;
      wait_acc_to(acc_count + 1);
      r1_valid = 1'b0;
      wait_rsp_to(2);

      // Contention: both held valid, grants must alternate starting with r0.
      done_delay = 3;
      exp_acc(0, 32'd4, 32'd5); exp_rsp(0, 67'd20, 1'b0, 5);
      exp_acc(1, 32'd6, 32'd7); exp_rsp(1, 67'd42, 1'b0, 5);
      exp_acc(0, 32'd4, 32'd5); exp_rsp(0, 67'd20, 1'b0, 5);
      r0_x = 32'd4; r0_y = 32'd5; r1_x = 32'd6; r1_y = 32'd7;
      r0_valid = 1'b1; r1_valid = 1'b1;
      wait_acc_to(acc_count + 3);
      r0_valid = 1'b0; r1_valid = 1'b0;
      wait_rsp_to(5);

      // Reset mid-WAIT abandons the multiply and restores r0 priority.
      done_delay = 30;
      exp_acc(0, 32'd9, 32'd9);
      r0_x = 32'd9; r0_y = 32'd9; r0_valid = 1'b1;
      wait_acc_to(acc_count + 1);
      r0_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("pre_reset_busy", PROD_W'(busy), PROD_W'(1));
      #2 rst = 1'b1;
      #1;
      check("async_mul_x", PROD_W'(mul_x), '0);
      check("async_mul_y", PROD_W'(mul_y), '0);
      check("async_busy", PROD_W'(busy), '0);
      check("async_product", rsp_product, '0);
      check("async_err", PROD_W'(rsp_err), '0);
      check("async_rsp0_valid", PROD_W'(rsp0_valid), '0);
      acc_q.delete(); launch_q.delete(); rsp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      done_delay = 3;
      exp_acc(0, 32'd10, 32'd11); exp_rsp(0, 67'd110, 1'b0, 5);
      exp_acc(1, 32'd12, 32'd13); exp_rsp(1, 67'd156, 1'b0, 5);
      r0_x = 32'd10; r0_y = 32'd11; r1_x = 32'd12; r1_y = 32'd13;
      r0_valid = 1'b1; r1_valid = 1'b1;
      a0 = acc_count;
      wait_acc_to(a0 + 1);
      r0_valid = 1'b0;
      wait_acc_to(a0 + 2);
      r1_valid = 1'b0;
      wait_rsp_to(7);

      // Watchdog: no done at all.
      done_en = 1'b0;
      exp_acc(1, 32'd1, 32'd1); exp_rsp(1, '0, 1'b1, 65);
      r1_x = 32'd1; r1_y = 32'd1; r1_valid = 1'b1;
      wait_acc_to(acc_count + 1);
      r1_valid = 1'b0;
      wait_rsp_to(8);
      done_en = 1'b1;

      // Done one cycle too late lands in RESP and must be ignored.
      done_delay = 64;
      exp_acc(0, 32'd3, 32'd3); exp_rsp(0, '0, 1'b1, 65);
      r0_x = 32'd3; r0_y = 32'd3; r0_valid = 1'b1;
      wait_acc_to(acc_count + 1);
      r0_valid = 1'b0;
      wait_rsp_to(9);

      // Done on the final watchdog cycle wins.
      done_delay = 63;
      exp_acc(1, 32'd5, 32'd6); exp_rsp(1, 67'd30, 1'b0, 65);
      r1_x = 32'd5; r1_y = 32'd6; r1_valid = 1'b1;
      wait_acc_to(acc_count + 1);
      r1_valid = 1'b0;
      wait_rsp_to(10);

      // Spurious done during LAUNCH is ignored.
      done_delay = 5;
      exp_acc(0, 32'd7, 32'd8); exp_rsp(0, 67'd56, 1'b0, 7);
      r0_x = 32'd7; r0_y = 32'd8; r0_valid = 1'b1;
      wait_acc_to(acc_count + 1);
      r0_valid = 1'b0;
      force_prod = 67'h123; force_done = 1'b1;
      @(posedge clk); #1;
      force_done = 1'b0;
      wait_rsp_to(11);

      // Backpressure: response held, r1 must wait.
      done_delay = 2;
      rsp0_ready = 1'b0;
      exp_acc(0, 32'd11, 32'd12); exp_rsp(0, 67'd132, 1'b0, 4);
      r0_x = 32'd11; r0_y = 32'd12; r0_valid = 1'b1;
      wait_acc_to(acc_count + 1);
      r0_valid = 1'b0;
      k = 0;
      while (!rsp0_valid && k < 100) begin
         @(negedge clk); k++;
      end
      check("bp_rsp_seen", PROD_W'(rsp0_valid), PROD_W'(1));
      r1_x = 32'd13; r1_y = 32'd2; r1_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_rsp0_valid", PROD_W'(rsp0_valid), PROD_W'(1));
         check("bp_product", rsp_product, 67'd132);
         check("bp_no_accept", PROD_W'(r1_ready), '0);
      end
      @(posedge clk); #1;
      exp_acc(1, 32'd13, 32'd2); exp_rsp(1, 67'd26, 1'b0, 4);
      rsp0_ready = 1'b1;
      wait_acc_to(acc_count + 1);
      r1_valid = 1'b0;
      wait_rsp_to(13);

      repeat (5) @(posedge clk);
      #1;
      check("acc_queue_empty", PROD_W'(acc_q.size()), '0);
      check("rsp_queue_empty", PROD_W'(rsp_q.size()), '0);
      check("final_idle", PROD_W'(busy), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one radix-8 Booth multiplier datapath between two requesters. It accepts an operand pair from one requester, launches the multiplier with a one-cycle start pulse, and waits for done under a watchdog. It then returns the 67-bit signed product to the granted requester through a valid/ready response. It sits between the ALU issue logic and the multiplier unit.

Parameters:
WIDTH, 32, operand width (X, Y signed two's complement)
PROD_W, 67, product width; fixed rule PROD_W = 2*WIDTH+3
TIMEOUT, 63, max WAIT cycles before error response; watchdog counter width = clog2(TIMEOUT+1)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
r0_valid  in  1  requester 0 has an operand pair
r0_ready  out  1  requester 0 operands accepted this cycle
r0_x, r0_y  in  WIDTH  requester 0 operands
r1_valid, r1_ready, r1_x, r1_y  as for requester 0
rsp0_valid, rsp1_valid  out  1  response pending for requester 0 / 1
rsp0_ready, rsp1_ready  in  1  requester consumes response
rsp_product  out  PROD_W  product, shared by both responses
rsp_err  out  1  watchdog expired; rsp_product = 0
mul_start  out  1  one-cycle launch pulse to the multiplier
mul_x, mul_y  out  WIDTH  registered operands to the multiplier
mul_done  in  1  multiplier finished; mul_product valid this cycle
mul_product  in  PROD_W  multiplier result
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, LAUNCH, WAIT, RESP. Encoding is free; one-hot is permitted.
- Reset (async, any state, including mid-operation):
  - State = IDLE; last_grant = 1, so requester 0 wins first.
  - All outputs 0: mul_x, mul_y, rsp_product, rsp_err, wd_cnt.
  - An in-flight multiply is abandoned. A later mul_done is ignored.
- IDLE:
  - Selection: sel = the only valid requester. If both are valid, sel = the requester != last_grant.
  - rN_ready = (state==IDLE) & rN_valid & (sel==N). This is combinational; at most one ready per cycle.
  - On handshake: capture rN_x/rN_y into mul_x/mul_y, set grant_id = sel, go to LAUNCH.
  - With no valid requester, stay in IDLE.
- LAUNCH:
  - mul_start = 1 for exactly this cycle; wd_cnt cleared; go to WAIT.
  - mul_x/mul_y are held stable from LAUNCH until leaving RESP.
- WAIT:
  - wd_cnt increments each cycle.
  - If mul_done: rsp_product <= mul_product, rsp_err <= 0, go to RESP.
  - Else if wd_cnt == TIMEOUT-1: rsp_product <= 0, rsp_err <= 1, go to RESP.
  - mul_done and timeout in the same cycle: done wins, no error.
- RESP:
  - rsp<grant_id>_valid = 1 and the other rsp valid = 0.
  - rsp_product/rsp_err are held until the handshake (valid & ready).
  - On handshake: last_grant <= grant_id, go to IDLE. The next request is accepted no earlier than the following cycle.
  - rspN_ready of the non-granted requester is ignored.
- mul_done outside WAIT is ignored, including in the LAUNCH cycle.
- Latency:
  - Request accepted at cycle T; mul_start at T+1.
  - If mul_done is at T+1+k (k >= 1), rsp valid at T+2+k.
  - Minimum accept-to-response is 3 cycles.
- Requests stay valid while waiting. The arbiter never drops or reorders a granted request.
- Fairness: with both requesters permanently valid, grants alternate 0,1,0,1...
- The product is passed through unmodified; no width or sign conversion is done here.

Test Plan:
- Single request: r0 X=2, Y=3; model done 15 cycles after start → rsp0_valid with rsp_product=6, rsp_err=0, r1 untouched; latency = 17 cycles from accept.
- Signed: r1 X=32'hFFFFFFFB (-5), Y=7 → rsp1 with rsp_product=67'h7_FFFF_FFFF_FFFF_FFDD (-35), rsp_err=0.
- Contention: r0 and r1 both valid continuously with distinct operands (4×5, 6×7) → grant order r0, r1, r0; products 20, 42, 20; exactly one rN_ready per accept.
- Watchdog: mul_done never asserted → after TIMEOUT=63 WAIT cycles rsp_err=1, rsp_product=0; a done arriving afterwards in RESP/IDLE is ignored.
- Backpressure and edges:
  - rsp0_ready held low 10 cycles → rsp0_valid and product stable, no new accept.
  - Done coincident with the timeout cycle → rsp_err=0.
  - Done in the LAUNCH cycle → ignored.
- Reset mid-WAIT: assert rst 1 cycle → all outputs 0 immediately (async), state IDLE; next r0/r1 simultaneous request grants r0.
